// File: rtl/core_mem_bridge.sv
// core_mem_bridge: per-core bridge between a CPU load/store port and one core
// port of the shared-memory interconnect.
//   - Stores are posted into a DEPTH-entry circular write buffer and drained
//     to the interconnect in order.
//   - Loads that hit a buffered store are answered the same cycle from the
//     youngest matching entry. Misses go to the interconnect ahead of any
//     older buffered stores.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   core_addr/core_wdata          core request address / store data
//   core_read/core_write          core requests, held until core_stall is low
//   core_rdata, core_stall        load data on completion; combinational stall
//   ic_addr, ic_write_data        registered interconnect address / store data
//   ic_read_enable/ic_write_enable registered interconnect requests
//   ic_read_data, ic_ready        interconnect return data; completion strobe
//   wbuf_count/full/empty         write-buffer occupancy
module core_mem_bridge #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AW-1:0]          core_addr,
  input  logic [DW-1:0]          core_wdata,
  input  logic                   core_read,
  input  logic                   core_write,
  output logic [DW-1:0]          core_rdata,
  output logic                   core_stall,
  output logic [AW-1:0]          ic_addr,
  output logic [DW-1:0]          ic_write_data,
  output logic                   ic_read_enable,
  output logic                   ic_write_enable,
  input  logic [DW-1:0]          ic_read_data,
  input  logic                   ic_ready,
  output logic [$clog2(DEPTH):0] wbuf_count,
  output logic                   wbuf_full,
  output logic                   wbuf_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WR, RD, RD_DONE} state_t;
  state_t state, state_n;

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] head, tail, nxt, idx;

  logic [AW-1:0] ic_addr_n;
  logic [DW-1:0] ic_wdata_n, load_q, load_n, hit_data;
  logic          ic_re_n, ic_we_n;
  logic          ld, st, push, pop, hit, ld_miss, rd_done;

  assign wbuf_full  = (wbuf_count == CW'(DEPTH));
  assign wbuf_empty = (wbuf_count == '0);

  // A simultaneous read+write is a load; the store half is dropped.
  assign ld      = core_read;
  assign st      = core_write & ~core_read;
  assign push    = st & ~wbuf_full;
  assign pop     = (state == WR) & ic_ready;
  assign rd_done = (state == RD_DONE);
  assign ld_miss = ld & ~hit;
  assign nxt     = head + PW'(1);

  // Scan oldest to youngest so the last match wins. The head stays valid
  // while it drains, so it still forwards until popped.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < wbuf_count) && (mem_addr[idx] == core_addr)) begin
        hit      = 1'b1;
        hit_data = mem_data[idx];
      end
    end
  end

  assign core_stall = (ld & ~hit & ~rd_done) | (st & wbuf_full);
  assign core_rdata = (ld & rd_done) ? load_q :
                      (ld & hit)     ? hit_data : '0;

  always_comb begin
    state_n    = state;
    ic_addr_n  = ic_addr;
    ic_wdata_n = ic_write_data;
    ic_re_n    = ic_read_enable;
    ic_we_n    = ic_write_enable;
    load_n     = load_q;
    case (state)
      IDLE: begin
        if (ld_miss) begin
          ic_addr_n = core_addr;
          ic_re_n   = 1'b1;
          state_n   = RD;
        end else if (!wbuf_empty) begin
          ic_addr_n  = mem_addr[head];
          ic_wdata_n = mem_data[head];
          ic_we_n    = 1'b1;
          state_n    = WR;
        end
      end
      WR: begin
        if (ic_ready) begin
          ic_we_n = 1'b0;
          if (ld_miss) begin
            ic_addr_n = core_addr;
            ic_re_n   = 1'b1;
            state_n   = RD;
          end else if (wbuf_count > CW'(1)) begin
            ic_addr_n  = mem_addr[nxt];
            ic_wdata_n = mem_data[nxt];
            ic_we_n    = 1'b1;
          end else if (push) begin
            // Last entry leaves as a new one lands at nxt this edge:
            // forward it straight from the core to avoid a bubble.
            ic_addr_n  = core_addr;
            ic_wdata_n = core_wdata;
            ic_we_n    = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      RD: begin
        if (ic_ready) begin
          load_n  = ic_read_data;
          ic_re_n = 1'b0;
          state_n = RD_DONE;
        end
      end
      RD_DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ic_addr         <= '0;
      ic_write_data   <= '0;
      ic_read_enable  <= 1'b0;
      ic_write_enable <= 1'b0;
      load_q          <= '0;
      head            <= '0;
      tail            <= '0;
      wbuf_count      <= '0;
    end else begin
      state           <= state_n;
      ic_addr         <= ic_addr_n;
      ic_write_data   <= ic_wdata_n;
      ic_read_enable  <= ic_re_n;
      ic_write_enable <= ic_we_n;
      load_q          <= load_n;
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= nxt;
      case ({push, pop})
        2'b10:   wbuf_count <= wbuf_count + CW'(1);
        2'b01:   wbuf_count <= wbuf_count - CW'(1);
        default: wbuf_count <= wbuf_count;
      endcase
    end
  end

  // Entry storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[tail] <= core_addr;
      mem_data[tail] <= core_wdata;
    end
  end
endmodule

// File: tb/tb_core_mem_bridge.sv
// tb_core_mem_bridge: self-checking bench for core_mem_bridge. An interconnect
// memory model answers reads; a reference model (store queue plus an
// architectural memory in program order) predicts occupancy, forwarding,
// drain order and load data.
module tb_core_mem_bridge;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] core_addr = '0, core_wdata = '0;
  logic       core_read = 1'b0, core_write = 1'b0;
  logic [7:0] core_rdata;
  logic       core_stall;
  logic [7:0] ic_addr, ic_write_data, ic_read_data;
  logic       ic_read_enable, ic_write_enable;
  logic       ic_ready = 1'b0;
  logic [2:0] wbuf_count;
  logic       wbuf_full, wbuf_empty;

  int errors = 0;
  int checks = 0;

  typedef struct packed { logic [7:0] a; logic [7:0] d; } ent_t;

  logic [7:0] ic_mem  [256];
  logic       ic_vld  [256];
  logic [7:0] ref_mem [256];

  always #5 clk = ~clk;

  core_mem_bridge #(.DEPTH(DEPTH), .AW(8), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_read(core_read), .core_write(core_write),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .ic_addr(ic_addr), .ic_write_data(ic_write_data),
    .ic_read_enable(ic_read_enable), .ic_write_enable(ic_write_enable),
    .ic_read_data(ic_read_data), .ic_ready(ic_ready),
    .wbuf_count(wbuf_count), .wbuf_full(wbuf_full), .wbuf_empty(wbuf_empty)
  );

  // Interconnect memory: unwritten locations read as addr ^ 8'hF3.
  always_comb ic_read_data = ic_vld[ic_addr] ? ic_mem[ic_addr] : (ic_addr ^ 8'hF3);

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ic_vld[i] <= 1'b0;
    end else if (ic_write_enable && ic_ready) begin
      ic_mem[ic_addr] <= ic_write_data;
      ic_vld[ic_addr] <= 1'b1;
    end
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; core_read = 1'b0; core_write = 1'b0; ic_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; core_read = 1'b0; core_write = 1'b0; ic_ready = 1'b0;
    @(negedge clk); #1;
    checks++; if (wbuf_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", wbuf_count); end
    checks++; if (wbuf_empty !== 1'b1 || wbuf_full !== 1'b0) begin errors++; $display("FAIL reset_flags got e%b f%b exp e1 f0", wbuf_empty, wbuf_full); end
    checks++; if ({ic_read_enable, ic_write_enable, ic_addr, ic_write_data} !== 18'd0) begin errors++; $display("FAIL reset_ic got re%b we%b a%h d%h exp all 0", ic_read_enable, ic_write_enable, ic_addr, ic_write_data); end
    checks++; if (core_stall !== 1'b0 || core_rdata !== 8'h00) begin errors++; $display("FAIL reset_core got stall%b rdata%h exp 0 00", core_stall, core_rdata); end
    rst = 1'b0;
  endtask

  task automatic test_fill_drain;
    logic [7:0] got_a [8];
    logic [7:0] got_d [8];
    int         got_c [8];
    int         n = 0;
    logic       acc = 1'b0;
    logic [7:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      core_write = 1'b1; core_addr = 8'hA0 + 8'(i); core_wdata = 8'(8'h11 * (i + 1));
      #1;
      checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL fill_stall%0d got %b exp 0", i, core_stall); end
    end
    @(negedge clk);
    core_addr = 8'hA4; core_wdata = 8'h55;
    #1;
    checks++; if (wbuf_count !== 3'd4 || wbuf_full !== 1'b1) begin errors++; $display("FAIL fill_full got cnt%0d f%b exp 4 1", wbuf_count, wbuf_full); end
    checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL fill_5th_stall got %b exp 1", core_stall); end
    checks++; if (ic_write_enable !== 1'b1 || ic_addr !== 8'hA0) begin errors++; $display("FAIL fill_head got we%b a%h exp 1 a0", ic_write_enable, ic_addr); end
    ic_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (acc) core_write = 1'b0;
        #1;
      end
      if (c == 1) begin
        checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL fill_5th_admit got stall %b exp 0", core_stall); end
      end
      if (core_write && !core_stall) acc = 1'b1;
      if (ic_write_enable && ic_ready && n < 8) begin
        got_a[n] = ic_addr; got_d[n] = ic_write_data; got_c[n] = c; n++;
      end
    end
    checks++; if (n !== 5) begin errors++; $display("FAIL drain_n got %0d exp 5", n); end
    for (int j = 0; j < 5 && j < n; j++) begin
      exp_d = 8'(8'h11 * (j + 1));
      checks++;
      if (got_a[j] !== 8'hA0 + 8'(j) || got_d[j] !== exp_d || got_c[j] !== j) begin
        errors++; $display("FAIL drain%0d got a%h d%h cyc%0d exp a%h d%h cyc%0d", j, got_a[j], got_d[j], got_c[j], 8'hA0 + 8'(j), exp_d, j);
      end
    end
    checks++; if (wbuf_count !== 3'd0 || wbuf_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got cnt%0d e%b exp 0 1", wbuf_count, wbuf_empty); end
  endtask

  task automatic test_forward;
    do_reset();
    @(negedge clk); core_write = 1'b1; core_addr = 8'h20; core_wdata = 8'h5A;
    @(negedge clk); core_wdata = 8'h6B;
    @(negedge clk); core_write = 1'b0; core_read = 1'b1;
    #1;
    checks++; if (core_stall !== 1'b0 || core_rdata !== 8'h6B) begin errors++; $display("FAIL fwd_youngest got stall%b rdata%h exp 0 6b", core_stall, core_rdata); end
    @(negedge clk); #1;
    checks++; if (ic_read_enable !== 1'b0) begin errors++; $display("FAIL fwd_no_read got %b exp 0", ic_read_enable); end
    core_read = 1'b0;
  endtask

  task automatic test_miss_latency;
    do_reset();
    ic_ready = 1'b1;
    @(negedge clk); core_read = 1'b1; core_addr = 8'h30;
    #1;
    checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL miss_c0 got stall %b exp 1", core_stall); end
    @(negedge clk); #1;
    checks++; if (core_stall !== 1'b1 || ic_read_enable !== 1'b1 || ic_addr !== 8'h30) begin errors++; $display("FAIL miss_c1 got stall%b re%b a%h exp 1 1 30", core_stall, ic_read_enable, ic_addr); end
    @(negedge clk); #1;
    checks++; if (core_stall !== 1'b0 || core_rdata !== 8'hC3) begin errors++; $display("FAIL miss_c2 got stall%b rdata%h exp 0 c3", core_stall, core_rdata); end
    @(negedge clk); core_read = 1'b0;
    #1;
    checks++; if (core_rdata !== 8'h00 || ic_read_enable !== 1'b0) begin errors++; $display("FAIL miss_after got rdata%h re%b exp 00 0", core_rdata, ic_read_enable); end
  endtask

  task automatic test_read_priority;
    logic [9:0] ev [$];
    logic [9:0] exp_ev [4];
    logic       done = 1'b0;
    exp_ev[0] = {2'd1, 8'h10}; exp_ev[1] = {2'd2, 8'h40};
    exp_ev[2] = {2'd3, 8'h00}; exp_ev[3] = {2'd1, 8'h11};
    do_reset();
    @(negedge clk); core_write = 1'b1; core_addr = 8'h10; core_wdata = 8'h81;
    @(negedge clk); core_addr = 8'h11; core_wdata = 8'h82;
    @(negedge clk); core_write = 1'b0; core_read = 1'b1; core_addr = 8'h40;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (done) core_read = 1'b0;
      end
      ic_ready = (c >= 3);
      #1;
      if (ic_ready && ic_write_enable) ev.push_back({2'd1, ic_addr});
      if (ic_ready && ic_read_enable)  ev.push_back({2'd2, ic_addr});
      if (core_read && !core_stall) begin
        ev.push_back({2'd3, 8'h00});
        done = 1'b1;
        checks++; if (core_rdata !== 8'hB3) begin errors++; $display("FAIL prio_rdata got %h exp b3", core_rdata); end
      end
    end
    checks++; if (ev.size() !== 4) begin errors++; $display("FAIL prio_events got %0d exp 4", ev.size()); end
    for (int j = 0; j < 4 && j < ev.size(); j++) begin
      checks++; if (ev[j] !== exp_ev[j]) begin errors++; $display("FAIL prio_ev%0d got %h exp %h", j, ev[j], exp_ev[j]); end
    end
  endtask

  task automatic test_reset_mid_read;
    do_reset();
    @(negedge clk); core_read = 1'b1; core_addr = 8'h71;
    @(negedge clk); #1;
    checks++; if (ic_read_enable !== 1'b1) begin errors++; $display("FAIL rstmid_in_rd got %b exp 1", ic_read_enable); end
    @(negedge clk); rst = 1'b1; core_read = 1'b0;
    @(negedge clk); rst = 1'b0;
    #1;
    checks++; if (ic_read_enable !== 1'b0 || ic_write_enable !== 1'b0) begin errors++; $display("FAIL rstmid_en got re%b we%b exp 0 0", ic_read_enable, ic_write_enable); end
    checks++; if (wbuf_count !== 3'd0 || core_stall !== 1'b0) begin errors++; $display("FAIL rstmid_state got cnt%0d stall%b exp 0 0", wbuf_count, core_stall); end
  endtask

  task automatic test_read_write_both;
    do_reset();
    ic_ready = 1'b1;
    @(negedge clk); core_read = 1'b1; core_write = 1'b1; core_addr = 8'h50; core_wdata = 8'hEE;
    #1;
    checks++; if (core_stall !== 1'b1 || wbuf_count !== 3'd0) begin errors++; $display("FAIL rw_c0 got stall%b cnt%0d exp 1 0", core_stall, wbuf_count); end
    @(negedge clk); #1;
    checks++; if (ic_read_enable !== 1'b1 || ic_write_enable !== 1'b0 || wbuf_count !== 3'd0) begin errors++; $display("FAIL rw_c1 got re%b we%b cnt%0d exp 1 0 0", ic_read_enable, ic_write_enable, wbuf_count); end
    @(negedge clk); #1;
    checks++; if (core_stall !== 1'b0 || core_rdata !== 8'hA3) begin errors++; $display("FAIL rw_c2 got stall%b rdata%h exp 0 a3", core_stall, core_rdata); end
    @(negedge clk); core_read = 1'b0; core_write = 1'b0;
    #1;
    checks++; if (wbuf_count !== 3'd0 || wbuf_empty !== 1'b1 || ic_vld[8'h50] !== 1'b0) begin errors++; $display("FAIL rw_end got cnt%0d e%b wr%b exp 0 1 0", wbuf_count, wbuf_empty, ic_vld[8'h50]); end
  endtask

  task automatic test_random;
    ent_t q [$];
    ent_t e;
    int   kind = 0, hold = 0, r;
    logic hit;
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hF3;
    for (int c = 0; c < 460; c++) begin
      @(negedge clk);
      if (kind == 0) begin
        core_read = 1'b0; core_write = 1'b0;
        if (c < 400) begin
          r = $urandom_range(0, 4);
          core_addr  = 8'h60 + 8'($urandom_range(0, 3));
          core_wdata = 8'($urandom);
          core_read  = (r == 2 || r == 4);
          core_write = (r == 1 || r == 3 || r == 4);
          kind = (r == 0) ? 0 : 1;
          hold = 0;
        end
      end
      ic_ready = (c >= 400) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      checks++; if (wbuf_count !== 3'(q.size()) || wbuf_full !== (q.size() == DEPTH) || wbuf_empty !== (q.size() == 0)) begin
        errors++; $display("FAIL rnd_occ c%0d got cnt%0d f%b e%b exp cnt%0d", c, wbuf_count, wbuf_full, wbuf_empty, q.size());
      end
      checks++; if (ic_read_enable && ic_write_enable) begin errors++; $display("FAIL rnd_both_en c%0d got 1 1 exp not both", c); end
      hit = 1'b0;
      foreach (q[j]) if (q[j].a == core_addr) hit = 1'b1;
      if (core_read) begin
        if (hit) begin
          checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL rnd_hit_stall c%0d got 1 exp 0", c); end
        end
        if (!core_stall) begin
          checks++; if (core_rdata !== ref_mem[core_addr]) begin errors++; $display("FAIL rnd_load c%0d a%h got %h exp %h", c, core_addr, core_rdata, ref_mem[core_addr]); end
        end
      end else begin
        checks++; if (core_rdata !== 8'h00) begin errors++; $display("FAIL rnd_rdata_idle c%0d got %h exp 00", c, core_rdata); end
        if (core_write) begin
          checks++; if (core_stall !== (q.size() == DEPTH)) begin errors++; $display("FAIL rnd_st_stall c%0d got %b exp %b", c, core_stall, q.size() == DEPTH); end
        end
      end
      if (ic_write_enable && ic_ready) begin
        checks++;
        if (q.size() == 0 || ic_addr !== q[0].a || ic_write_data !== q[0].d) begin
          errors++; $display("FAIL rnd_drain c%0d got a%h d%h exp head of %0d entries", c, ic_addr, ic_write_data, q.size());
        end
        if (q.size() > 0) e = q.pop_front();
      end
      if (core_write && !core_read && !core_stall) begin
        e.a = core_addr; e.d = core_wdata;
        q.push_back(e);
        ref_mem[core_addr] = core_wdata;
      end
      if (kind != 0) begin
        hold++;
        if (!core_stall) kind = 0;
        else if (hold > 60) begin
          errors++; checks++; $display("FAIL rnd_timeout c%0d got stalled %0d cycles exp <=60", c, hold);
          kind = 0;
        end
      end
    end
    @(negedge clk); #1;
    checks++; if (wbuf_count !== 3'd0 || q.size() !== 0) begin errors++; $display("FAIL rnd_final_count got %0d model %0d exp 0", wbuf_count, q.size()); end
    for (int a = 8'h60; a < 8'h64; a++) begin
      checks++;
      if ((ic_vld[a] ? ic_mem[a] : (8'(a) ^ 8'hF3)) !== ref_mem[a]) begin
        errors++; $display("FAIL rnd_mem a%h got %h exp %h", a, ic_vld[a] ? ic_mem[a] : (8'(a) ^ 8'hF3), ref_mem[a]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_forward();
    test_miss_latency();
    test_read_priority();
    test_reset_mid_read();
    test_read_write_both();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
